rng_byte_source: RTL

//   Upstream producer for the 64-byte RNG shift buffer. Mixes a Galois LFSR with a raw

---
 rtl/rng_byte_source.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rng_byte_source.sv
// ============================================================================
// rng_byte_source : LFSR/entropy mixer with von Neumann debias, byte packer
// Revision 1.0
// ============================================================================
`default_nettype none

module rng_byte_source #(
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] SEED      = 32'hACE12468,
    parameter logic [LFSR_W-1:0] TAPS      = 32'h80200003,
    parameter int                BURST_LEN = 64,
    parameter int                CNT_W     = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              entropy_i,
    input  logic              bypass_i,
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              write_o,
    output logic [7:0]        data_o,
    output logic [CNT_W-1:0]  byte_cnt_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_RUN    = 2'd1;
    localparam logic [1:0]       S_DONE   = 2'd2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    logic [1:0]        state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              phase_q, phase_d;
    logic              b0_q, b0_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        sr_q, sr_d;
    logic [7:0]        data_q, data_d;
    logic              write_q, write_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              w_raw;
    logic              w_accept;
    logic              w_byte_done;
    logic [LFSR_W-1:0] w_lfsr_step;

    assign w_lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    assign w_raw       = bypass_i ? entropy_i : (lfsr_q[0] ^ entropy_i);
    // Abort wins over byte completion, so it masks acceptance entirely.
    assign w_accept    = (state_q == S_RUN) && phase_q && (b0_q != w_raw) && !abort_i;
    assign w_byte_done = w_accept && (bitcnt_q == 3'd7);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (abort_i)                                 state_d = S_IDLE;
                else if (w_byte_done && (cnt_q == LAST_CNT)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        busy_o = (state_q == S_RUN);
        done_o = (state_q == S_DONE);
    end

    always_comb begin
        lfsr_d   = lfsr_q;
        phase_d  = phase_q;
        b0_d     = b0_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        data_d   = data_q;
        write_d  = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (seed_load_i) lfsr_d = (seed_i == '0) ? SEED : seed_i;
                if (start_i) begin
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    phase_d  = 1'b0;
                    sr_d     = '0;
                end
            end
            S_RUN: begin
                lfsr_d  = w_lfsr_step;
                phase_d = ~phase_q;
                if (abort_i) begin
                    phase_d  = 1'b0;
                    bitcnt_d = '0;
                    sr_d     = '0;
                end else if (!phase_q) begin
                    b0_d = w_raw;
                end else if (w_accept) begin
                    sr_d     = {sr_q[6:0], b0_q};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (w_byte_done) begin
                        data_d  = {sr_q[6:0], b0_q};
                        write_d = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lfsr_q   <= SEED;
            phase_q  <= 1'b0;
            b0_q     <= 1'b0;
            bitcnt_q <= '0;
            sr_q     <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            phase_q  <= phase_d;
            b0_q     <= b0_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            data_q   <= data_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
        end
    end

    assign write_o    = write_q;
    assign data_o     = data_q;
    assign byte_cnt_o = cnt_q;

endmodule

`default_nettype wire
